// File: rtl/glb_pkg.sv
// Shared mask-buffer definitions: default geometry, response FIFO depth
// and the clear-sequencer state encoding.
package glb_pkg;

    localparam int SRAM_WIDTH_DEF      = 256;
    localparam int MASK_ADDR_WIDTH_DEF = 5;
    localparam int RSP_FIFO_DEPTH      = 2;

    typedef enum logic {
        IDLE = 1'b0,
        CLR  = 1'b1
    } clrState_t;

endpackage

// File: rtl/mask_rsp_fifo.sv
// Two-entry response FIFO; head is presented combinationally on dout
// and entries reset to zero so dout reads 0 out of reset.
module mask_rsp_fifo
    import glb_pkg::*;
#(
    parameter int WIDTH = SRAM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot [2];
    logic             wrPtr;
    logic             rdPtr;
    logic [1:0]       cnt;

    // Storage, pointers and occupancy; push+pop together keeps cnt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wrPtr   <= 1'b0;
            rdPtr   <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (push) begin
                slot[wrPtr] <= din;
                wrPtr       <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = slot[rdPtr];
    assign full  = (cnt == 2'(RSP_FIFO_DEPTH));
    assign empty = (cnt == 2'd0);
    assign count = cnt;

endmodule

// File: rtl/mask_rd_rsp.sv
// Mask word buffer: write port, credit-limited read port, 2-deep response FIFO.
// Optional macro MASK_RD_RSP_CLR_EN adds CTRGLB_MaskClr and a zero-fill sequencer.
module mask_rd_rsp
    import glb_pkg::*;
#(
    parameter int SRAM_WIDTH      = SRAM_WIDTH_DEF,
    parameter int MASK_ADDR_WIDTH = MASK_ADDR_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef MASK_RD_RSP_CLR_EN
    input  logic                       CTRGLB_MaskClr,
`endif
    input  logic [MASK_ADDR_WIDTH-1:0] CTRGLB_MaskWrAddr,
    input  logic [SRAM_WIDTH-1:0]      CTRGLB_MaskWrDat,
    input  logic                       CTRGLB_MaskWrVld,
    output logic                       GLBCTR_MaskWrRdy,
    input  logic [MASK_ADDR_WIDTH-1:0] PSSGLB_MaskRdAddr,
    input  logic                       PSSGLB_MaskRdAddrVld,
    output logic                       GLBPSS_MaskRdAddrRdy,
    output logic [SRAM_WIDTH-1:0]      GLBPSS_MaskDatOut,
    output logic                       GLBPSS_MaskDatOutVld,
    input  logic                       PSSGLB_MaskDatRdy
);

    localparam int DEPTH = 2 ** MASK_ADDR_WIDTH;

    logic [SRAM_WIDTH-1:0] mem [DEPTH];
    logic [SRAM_WIDTH-1:0] rdData;
    logic                  live;
    logic                  inFlight;
    logic                  clrBusy;
    logic                  wrAcc;
    logic                  rdAcc;
    logic [1:0]            credit;

    logic [SRAM_WIDTH-1:0] fifoDout;
    logic                  fifoPop;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [1:0]            fifoCnt;

`ifdef MASK_RD_RSP_CLR_EN
    clrState_t                state;
    logic [MASK_ADDR_WIDTH-1:0] clrCnt;

    // Clear sequencer: sweep every word to zero, starting out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CLR;
            clrCnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (CTRGLB_MaskClr) begin
                        state  <= CLR;
                        clrCnt <= '0;
                    end
                end
                CLR: begin
                    clrCnt <= clrCnt + 1'b1;
                    if (clrCnt == MASK_ADDR_WIDTH'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign clrBusy = (state == CLR);
`else
    assign clrBusy = 1'b0;
`endif

    // Free slots left once queued and in-flight responses are counted
    assign credit = fifoFull ? 2'd0
                  : 2'(RSP_FIFO_DEPTH) - fifoCnt - {1'b0, inFlight};

    assign fifoPop = ~fifoEmpty & PSSGLB_MaskDatRdy;

    assign GLBCTR_MaskWrRdy     = live & ~clrBusy;
    assign GLBPSS_MaskRdAddrRdy = live & ~clrBusy & ~CTRGLB_MaskWrVld
                                & ((credit != 2'd0) | fifoPop);

    assign wrAcc = CTRGLB_MaskWrVld & GLBCTR_MaskWrRdy;
    assign rdAcc = PSSGLB_MaskRdAddrVld & GLBPSS_MaskRdAddrRdy;

    // Array port: one write (clear or host) or one read per cycle
    always_ff @(posedge clk) begin
`ifdef MASK_RD_RSP_CLR_EN
        if (clrBusy) begin
            mem[clrCnt] <= '0;
        end else if (wrAcc) begin
            mem[CTRGLB_MaskWrAddr] <= CTRGLB_MaskWrDat;
        end
`else
        if (wrAcc) begin
            mem[CTRGLB_MaskWrAddr] <= CTRGLB_MaskWrDat;
        end
`endif
    end

    // Read capture and in-flight tracking; live opens the ports after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live     <= 1'b0;
            inFlight <= 1'b0;
            rdData   <= '0;
        end else begin
            live     <= 1'b1;
            inFlight <= rdAcc;
            if (rdAcc) begin
                rdData <= mem[PSSGLB_MaskRdAddr];
            end
        end
    end

    mask_rsp_fifo #(
        .WIDTH (SRAM_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inFlight),
        .din   (rdData),
        .pop   (fifoPop),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCnt)
    );

    assign GLBPSS_MaskDatOut    = fifoDout;
    assign GLBPSS_MaskDatOutVld = ~fifoEmpty;

endmodule

// File: tb/tb_mask_rd_rsp.sv
// Bench for mask_rd_rsp: queue-based response model checked every cycle
// plus directed scenarios with literal expectations.
module tb_mask_rd_rsp;
    import glb_pkg::*;

    localparam int W  = 256;
    localparam int AW = 5;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] wrAddr = '0;
    logic [W-1:0]  wrDat = '0;
    logic          wrVld = 1'b0;
    logic          wrRdy;
    logic [AW-1:0] rdAddr = '0;
    logic          rdAddrVld = 1'b0;
    logic          rdAddrRdy;
    logic [W-1:0]  datOut;
    logic          datOutVld;
    logic          datRdy = 1'b1;
`ifdef MASK_RD_RSP_CLR_EN
    logic          clr = 1'b0;
`endif

    always #5 clk = ~clk;

    mask_rd_rsp #(
        .SRAM_WIDTH      (W),
        .MASK_ADDR_WIDTH (AW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
`ifdef MASK_RD_RSP_CLR_EN
        .CTRGLB_MaskClr       (clr),
`endif
        .CTRGLB_MaskWrAddr    (wrAddr),
        .CTRGLB_MaskWrDat     (wrDat),
        .CTRGLB_MaskWrVld     (wrVld),
        .GLBCTR_MaskWrRdy     (wrRdy),
        .PSSGLB_MaskRdAddr    (rdAddr),
        .PSSGLB_MaskRdAddrVld (rdAddrVld),
        .GLBPSS_MaskRdAddrRdy (rdAddrRdy),
        .GLBPSS_MaskDatOut    (datOut),
        .GLBPSS_MaskDatOutVld (datOutVld),
        .PSSGLB_MaskDatRdy    (datRdy)
    );

    typedef struct {
        logic [W-1:0] d;
        int           vis;
    } ent_t;

    int           tests = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] memM [D];
    ent_t         q[$];
    bit           liveM = 1'b0;
    logic [W-1:0] popLog[$];
    int           popCyc[$];
`ifdef MASK_RD_RSP_CLR_EN
    int           clrLeft = D;
`endif

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i + 8'h40);
        return {32{b}};
    endfunction

    // Model: every accepted read becomes visible two negedges later,
    // at most two responses outstanding, a pop frees a slot at once.
    always @(negedge clk) begin
        bit vE, rE, wE, pop, busy;
        cyc++;
        if (rst) begin
            chk("rst_vld", W'(datOutVld), '0);
            chk("rst_dat", datOut, '0);
            chk("rst_rdrdy", W'(rdAddrRdy), '0);
            chk("rst_wrrdy", W'(wrRdy), '0);
            q.delete();
            liveM = 1'b0;
`ifdef MASK_RD_RSP_CLR_EN
            clrLeft = D;
            for (int i = 0; i < D; i++) memM[i] = '0;
`endif
        end else begin
            busy = 1'b0;
`ifdef MASK_RD_RSP_CLR_EN
            busy = (clrLeft > 0);
`endif
            vE  = (q.size() > 0) && (q[0].vis <= cyc);
            pop = vE && datRdy;
            rE  = liveM && !busy && !wrVld && ((q.size() < 2) || pop);
            wE  = liveM && !busy;
            chk("vld", W'(datOutVld), W'(vE));
            chk("rdrdy", W'(rdAddrRdy), W'(rE));
            chk("wrrdy", W'(wrRdy), W'(wE));
            if (vE) chk("dat", datOut, q[0].d);
            if (datOutVld && datRdy) begin
                popLog.push_back(datOut);
                popCyc.push_back(cyc);
            end
            if (pop) void'(q.pop_front());
            if (rdAddrVld && rE) q.push_back(ent_t'{memM[rdAddr], cyc + 2});
            if (wrVld && wE) memM[wrAddr] = wrDat;
`ifdef MASK_RD_RSP_CLR_EN
            if (busy) clrLeft--;
            else if (clr) begin
                clrLeft = D;
                for (int i = 0; i < D; i++) memM[i] = '0;
            end
`endif
            liveM = 1'b1;
        end
    end

    task automatic stepC;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        bit ok;
        ok = 1'b0;
        wrAddr = AW'(a);
        wrDat  = d;
        wrVld  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wrRdy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wr_timeout", W'(ok), W'(1));
        stepC();
        wrVld = 1'b0;
    endtask

    task automatic rd(input int a);
        bit ok;
        ok = 1'b0;
        rdAddr    = AW'(a);
        rdAddrVld = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rdAddrRdy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rd_timeout", W'(ok), W'(1));
        stepC();
        rdAddrVld = 1'b0;
    endtask

    logic [W-1:0] xDat;

    initial begin
        int n0, hi, miss, busyN, nz;
        xDat = {8{32'hC0DE0007}};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        stepC();
`ifndef MASK_RD_RSP_CLR_EN
        chk("exit_wrrdy", W'(wrRdy), W'(1));
        chk("exit_rdrdy", W'(rdAddrRdy), W'(1));
`else
        repeat (D + 2) stepC();
`endif
        for (int i = 0; i < D; i++) wr(i, pat(i));

        // Write then read word 3, latency check
        wr(3, W'(8'hA5));
        rdAddr    = 5'd3;
        rdAddrVld = 1'b1;
        @(negedge clk);
        chk("t35_acc", W'(rdAddrRdy), W'(1));
        stepC();
        rdAddrVld = 1'b0;
        @(negedge clk);
        chk("t35_lat0", W'(datOutVld), '0);
        @(negedge clk);
        chk("t35_lat1", W'(datOutVld), W'(1));
        chk("t35_dat", W'(datOut[7:0]), W'(8'hA5));
        stepC();

        // Backpressure: two accepted, third blocked until a pop
        datRdy = 1'b0;
        n0 = popLog.size();
        rd(0);
        rd(1);
        rdAddr    = 5'd2;
        rdAddrVld = 1'b1;
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdAddrRdy) hi++;
        end
        chk("t36_blocked", W'(hi), '0);
        stepC();
        datRdy = 1'b1;
        @(negedge clk);
        chk("t36_popfree", W'(rdAddrRdy), W'(1));
        stepC();
        rdAddrVld = 1'b0;
        repeat (4) stepC();
        chk("t36_cnt", W'(popLog.size() - n0), W'(3));
        chk("t36_o0", popLog[n0], pat(0));
        chk("t36_o1", popLog[n0+1], pat(1));
        chk("t36_o2", popLog[n0+2], pat(2));

        // Write and read collide: write wins, read follows with new data
        wrAddr    = 5'd7;
        wrDat     = xDat;
        wrVld     = 1'b1;
        rdAddr    = 5'd7;
        rdAddrVld = 1'b1;
        @(negedge clk);
        chk("t37_rdblk", W'(rdAddrRdy), '0);
        chk("t37_wrrdy", W'(wrRdy), W'(1));
        stepC();
        wrVld = 1'b0;
        @(negedge clk);
        chk("t37_rdacc", W'(rdAddrRdy), W'(1));
        stepC();
        rdAddrVld = 1'b0;
        repeat (3) stepC();
        chk("t37_dat", popLog[popLog.size()-1], xDat);

        // Streaming reads 0..31 at one per cycle
        n0 = popLog.size();
        miss = 0;
        for (int i = 0; i < D; i++) begin
            rdAddr    = AW'(i);
            rdAddrVld = 1'b1;
            @(negedge clk);
            if (!rdAddrRdy) miss++;
            stepC();
        end
        rdAddrVld = 1'b0;
        repeat (4) stepC();
        chk("t38_miss", W'(miss), '0);
        chk("t38_cnt", W'(popLog.size() - n0), W'(D));
        chk("t38_span", W'(popCyc[popCyc.size()-1] - popCyc[n0]), W'(D - 1));
        chk("t38_w3", W'(popLog[n0+3][7:0]), W'(8'hA5));
        chk("t38_w7", popLog[n0+7], xDat);
        chk("t38_w31", popLog[n0+31], pat(31));

        // Reset with two responses pending
        datRdy = 1'b0;
        rd(1);
        rd(2);
        repeat (2) stepC();
        chk("t39_pend", W'(datOutVld), W'(1));
        rst = 1'b1;
        #1;
        chk("t39_vldnow", W'(datOutVld), '0);
        chk("t39_datnow", datOut, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        datRdy = 1'b1;
        n0 = popLog.size();
        repeat (6) stepC();
        chk("t39_stale", W'(popLog.size() - n0), '0);

`ifdef MASK_RD_RSP_CLR_EN
        repeat (D + 2) stepC();
        for (int i = 0; i < D; i++) wr(i, '1);
        clr = 1'b1;
        @(negedge clk);
        stepC();
        clr = 1'b0;
        busyN = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!rdAddrRdy) busyN++;
            else break;
        end
        chk("t40_busy", W'(busyN), W'(D));
        stepC();
        n0 = popLog.size();
        for (int i = 0; i < D; i++) rd(i);
        repeat (4) stepC();
        chk("t40_cnt", W'(popLog.size() - n0), W'(D));
        nz = 0;
        for (int i = n0; i < popLog.size(); i++) if (popLog[i] != '0) nz++;
        chk("t40_zero", W'(nz), '0);
`endif

        repeat (3) stepC();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/mask_rd_rsp.md
MASK_RD_RSP -- requirements
Module: mask_rd_rsp

Interface
REQ-001 SHALL have parameter SRAM_WIDTH, default 256, mask word width in bits.
REQ-002 SHALL have parameter MASK_ADDR_WIDTH, default 5, word address width; DEPTH = 2**MASK_ADDR_WIDTH.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 CTRGLB_MaskWrAddr  in  MASK_ADDR_WIDTH  write word address.
REQ-006 CTRGLB_MaskWrDat  in  SRAM_WIDTH  write data.
REQ-007 CTRGLB_MaskWrVld  in  1  write valid.
REQ-008 GLBCTR_MaskWrRdy  out  1  write ready.
REQ-009 PSSGLB_MaskRdAddr  in  MASK_ADDR_WIDTH  read word address.
REQ-010 PSSGLB_MaskRdAddrVld  in  1  read-address valid.
REQ-011 GLBPSS_MaskRdAddrRdy  out  1  read-address ready.
REQ-012 GLBPSS_MaskDatOut  out  SRAM_WIDTH  read data.
REQ-013 GLBPSS_MaskDatOutVld  out  1  read-data valid.
REQ-014 PSSGLB_MaskDatRdy  in  1  read-data ready.

Function
REQ-015 SHALL hold a DEPTH x SRAM_WIDTH array with a single access per cycle.
REQ-016 A write SHALL be accepted on WrVld & WrRdy; WrRdy is 1 outside reset and outside clear.
REQ-017 Writes SHALL have priority: RdAddrRdy = 0 in any cycle where WrVld = 1.
REQ-018 A read SHALL be accepted on RdAddrVld & RdAddrRdy; the array is read in the same edge, and the data enters the response FIFO one cycle later.
REQ-019 The response FIFO SHALL hold 2 entries; credit = 2 - (FIFO count + in-flight reads); RdAddrRdy = 0 when credit = 0.
REQ-020 DatOutVld SHALL be 1 whenever the FIFO is non-empty; DatOut SHALL be the FIFO head; it is popped on DatOutVld & DatRdy.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged; with 2 pending, a pop SHALL allow a new read accept in the same cycle.
REQ-022 Responses SHALL return in request order, one per accepted address.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-024 Maximum throughput SHALL be one read per cycle with DatRdy held at 1; read latency SHALL be 1 cycle from address accept to DatOutVld.
REQ-025 A held DatOut SHALL stay stable while DatOutVld = 1 and DatRdy = 0.

Reset
REQ-026 On rst: FIFO empty, in-flight flag 0, DatOutVld 0, DatOut 0, RdAddrRdy 0, WrRdy 0; array contents are not reset.
REQ-027 In the first cycle after rst deasserts, RdAddrRdy and WrRdy SHALL be 1 (clear macro off).
REQ-028 Reset asserted mid-operation SHALL discard pending reads without emitting them.

Configuration
REQ-029 Macro MASK_RD_RSP_CLR_EN SHALL add input CTRGLB_MaskClr (1 bit) and a two-state FSM, IDLE/CLR.
REQ-030 Entering CLR:
- Taken on Clr = 1 in IDLE.
- In CLR, a 0-valued word is written to address cnt each cycle, cnt running 0..DEPTH-1.
- After writing DEPTH-1, the FSM returns to IDLE.
- RdAddrRdy and WrRdy are 0 throughout CLR.
- Already-queued responses still drain.
REQ-031 Reset state and leaving reset:
- Reset state with the macro is CLR with cnt = 0.
- The array is zeroed automatically after reset; ready rises DEPTH cycles after reset.
REQ-032 Without the macro there SHALL be no port, no FSM and no clear behaviour.

Structure
REQ-033 Shared package glb_pkg SHALL hold SRAM_WIDTH/MASK_ADDR_WIDTH defaults and the FSM state enum.
REQ-034 The 2-entry FIFO SHALL be sub-module mask_rsp_fifo (parameter width, push/pop, full/empty, count).

Verification
REQ-035 Write addr 3 = 0xA5 (lower byte), then read addr 3 -> DatOut[7:0] = 0xA5, DatOutVld exactly 1 cycle after accept.
REQ-036 DatRdy = 0, issue reads 0,1,2 -> two accepted, RdAddrRdy = 0 until the first pop; outputs arrive in order 0,1,2.
REQ-037 WrVld = 1 and RdAddrVld = 1 in the same cycle -> write performed, read accepted the next cycle, returning the written data.
REQ-038 Back-to-back reads 0..31 with DatRdy = 1 -> 32 responses in 32 consecutive cycles.
REQ-039 Assert rst with 2 responses pending -> DatOutVld = 0 immediately and no stale data after release.
REQ-040 With MASK_RD_RSP_CLR_EN:
- Write all-ones to all words, then pulse Clr.
- RdAddrRdy = 0 for 32 cycles.
- Every subsequent read returns 0.
